// File: rtl/sar_adc_ctrl_if.sv
// Handshake and DAC/comparator bundle between the SAR controller and its surroundings.
// master = controller side, slave = consumer/analog-front-end side.
interface sar_adc_ctrl_if #(
  parameter int N = 8
);
  logic         soc;
  logic         eoc;
  logic [N-1:0] x;
  logic [N-1:0] dac;
  logic         cmp;

  modport master (input soc, input cmp, output eoc, output x, output dac);
  modport slave  (output soc, output cmp, input eoc, input x, input dac);
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: resolves one bit per step, MSB first, via an external DAC/comparator.
// Optional build macro SAR_MAJORITY_EN: each bit decision is the majority of three comparator samples.
module sar_adc_ctrl #(
  parameter int N      = 8,
  parameter int SETTLE = 1
) (
  input  logic             clock,
  input  logic             reset_,
  sar_adc_ctrl_if.master   bus
);

  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_DECIDE,
    S_WAIT
  } state_t;

  state_t        state;
  logic          eoc_r;
  logic [N-1:0]  x_r;
  logic [N-1:0]  dac_r;
  logic [BW-1:0] bidx;
  logic [CW-1:0] cnt;
  logic          dec_ready;
  logic          dec_bit;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

`ifdef SAR_MAJORITY_EN
  logic [1:0] samp;
  logic [1:0] dcnt;

  // Decision lands on the third DECIDE cycle, combining the two stored samples with the live one.
  always_comb begin
    dec_ready = (dcnt == 2'd2);
    dec_bit   = maj3(samp[1], samp[0], bus.cmp);
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      samp <= '0;
      dcnt <= '0;
    end else if (state == S_DECIDE) begin
      samp <= {samp[0], bus.cmp};
      dcnt <= dec_ready ? 2'd0 : dcnt + 2'd1;
    end else begin
      dcnt <= '0;
    end
  end
`else
  always_comb begin
    dec_ready = 1'b1;
    dec_bit   = maj3(bus.cmp, bus.cmp, bus.cmp);
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state <= S_IDLE;
      eoc_r <= 1'b1;
      x_r   <= '0;
      dac_r <= '0;
      bidx  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.soc) begin
            eoc_r <= 1'b0;
            dac_r <= '0;
            dac_r[N-1] <= 1'b1;
            bidx  <= BW'(N - 1);
            cnt   <= '0;
            state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(SETTLE - 1)) state <= S_DECIDE;
        end
        S_DECIDE: begin
          if (dec_ready) begin
            if (!dec_bit) dac_r[bidx] <= 1'b0;
            if (bidx == '0) begin
              state <= S_WAIT;
            end else begin
              // Next trial bit is raised on the same edge the current one is resolved.
              dac_r[bidx - 1'b1] <= 1'b1;
              bidx  <= bidx - 1'b1;
              cnt   <= '0;
              state <= S_SETTLE;
            end
          end
        end
        S_WAIT: begin
          // Result is published only once the consumer has dropped soc.
          if (!bus.soc) begin
            x_r   <= dac_r;
            eoc_r <= 1'b1;
            dac_r <= '0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.eoc = eoc_r;
  assign bus.x   = x_r;
  assign bus.dac = dac_r;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed bench for sar_adc_ctrl: table of conversions plus reset-abort and idle-hold sequences.
module tb_sar_adc_ctrl;

  localparam int N = 8;
`ifdef SAR_MAJORITY_EN
  localparam int LAT = 33;
`else
  localparam int LAT = 17;
`endif

  typedef struct {
    logic [7:0] a;
    int         hold;
    bit         toggle;
    bit         inj;
    bit         chk_seq;
    logic [7:0] x_exp;
    int         lat_exp;
  } vec_t;

  logic       clock;
  logic       reset_;
  logic [7:0] a;
  logic       inj;
  int         total;
  int         bad;

  sar_adc_ctrl_if #(.N(N)) bus ();

  sar_adc_ctrl #(.N(N), .SETTLE(1)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign bus.cmp = (a >= bus.dac) ^ inj;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs one conversion starting from IDLE; checks x hold, latency, final x/dac and optionally the dac trial sequence.
  task automatic run_conv(input vec_t v, input logic [7:0] old_x);
    int         cyc;
    int         lat;
    int         nchg;
    bit         x_held;
    logic [7:0] prev;
    logic [7:0] seq [8];
    logic [7:0] seq_exp [8];
    seq_exp = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hB8, 8'hB4, 8'hB6, 8'hB5};
    a = v.a;
    cyc = 0; lat = 0; nchg = 0; x_held = 1'b1; prev = 8'h00;
    bus.soc = 1'b1;
    inj = 1'b0;
    step();
    cyc = 1;
    while (bus.eoc === 1'b0 && cyc < 200) begin
      lat++;
      if (bus.x !== old_x) x_held = 1'b0;
      if (bus.dac !== prev) begin
        if (nchg < 8) seq[nchg] = bus.dac;
        nchg++;
        prev = bus.dac;
      end
      if (v.toggle) bus.soc = (cyc < 14) ? logic'(cyc % 2) : 1'b0;
      else          bus.soc = (cyc < v.hold) ? 1'b1 : 1'b0;
      inj = v.inj && (cyc % 4 == 2);
      step();
      cyc++;
    end
    inj = 1'b0;
    if (cyc >= 200) chk("conv_timeout", 32'(cyc), 32'd0);
    chk("x_held_during_conv", 32'(x_held), 32'd1);
    chk("eoc_low_cycles", 32'(lat), 32'(v.lat_exp));
    chk("x_result", 32'(bus.x), 32'(v.x_exp));
    chk("dac_cleared", 32'(bus.dac), 32'd0);
    if (v.chk_seq) begin
      chk("dac_seq_len", 32'(nchg), 32'd8);
      for (int i = 0; i < 8; i++) chk($sformatf("dac_seq[%0d]", i), 32'(seq[i]), 32'(seq_exp[i]));
    end
  endtask

  vec_t       vecs [6];
  int         nv;
  logic [7:0] last_x;

  initial begin
    total = 0; bad = 0;
    a = 8'h00; inj = 1'b0;
    bus.soc = 1'b0;
    reset_ = 1'b0;

    nv = 0;
    vecs[nv++] = '{8'hB5, 1,  1'b0, 1'b0, 1'b1, 8'hB5, LAT};
    vecs[nv++] = '{8'h00, 1,  1'b0, 1'b0, 1'b0, 8'h00, LAT};
    vecs[nv++] = '{8'hFF, 1,  1'b0, 1'b0, 1'b0, 8'hFF, LAT};
    vecs[nv++] = '{8'h3C, 30, 1'b0, 1'b0, 1'b0, 8'h3C, (LAT > 30) ? LAT : 30};
    vecs[nv++] = '{8'hB5, 1,  1'b1, 1'b0, 1'b0, 8'hB5, LAT};
`ifdef SAR_MAJORITY_EN
    vecs[nv++] = '{8'hB5, 1,  1'b0, 1'b1, 1'b0, 8'hB5, LAT};
`endif

    repeat (3) step();
    reset_ = 1'b1;
    chk("rst_eoc", 32'(bus.eoc), 32'd1);
    chk("rst_x", 32'(bus.x), 32'd0);
    chk("rst_dac", 32'(bus.dac), 32'd0);

    // Back-to-back table: each run starts on the edge right after eoc rose.
    last_x = 8'h00;
    for (int i = 0; i < nv; i++) begin
      run_conv(vecs[i], last_x);
      last_x = vecs[i].x_exp;
      if (vecs[i].hold > 1) begin
        repeat (2) step();
        chk("no_restart_eoc", 32'(bus.eoc), 32'd1);
        chk("no_restart_x", 32'(bus.x), 32'(vecs[i].x_exp));
      end
    end

    // Reset five cycles into a conversion.
    a = 8'h77;
    bus.soc = 1'b1;
    step();
    bus.soc = 1'b0;
    repeat (4) step();
    chk("mid_eoc_low", 32'(bus.eoc), 32'd0);
    reset_ = 1'b0;
    step();
    reset_ = 1'b1;
    chk("abort_eoc", 32'(bus.eoc), 32'd1);
    chk("abort_x", 32'(bus.x), 32'd0);
    chk("abort_dac", 32'(bus.dac), 32'd0);
    step();
    chk("abort_stays_idle", 32'(bus.eoc), 32'd1);
    run_conv('{8'h5A, 1, 1'b0, 1'b0, 1'b0, 8'h5A, LAT}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
